// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin front end for a tick-driven UART transmitter
module uart_tx_arbiter #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            req0,
   input  logic [DBIT-1:0] din0,
   input  logic            req1,
   input  logic [DBIT-1:0] din1,
   output logic            gnt0,
   output logic            gnt1,
   output logic            src,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);
   localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [SW-1:0] s, s_n;
   logic [NW-1:0] n, n_n;
   logic [DBIT-1:0] b, b_n;
   logic rr, rr_n, src_n, tx_n;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         b     <= '0;
         rr    <= 1'b0;
         src   <= 1'b0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         s     <= s_n;
         n     <= n_n;
         b     <= b_n;
         rr    <= rr_n;
         src   <= src_n;
         tx    <= tx_n;
      end
   end
   always_comb begin
      state_n      = state;
      s_n          = s;
      n_n          = n;
      b_n          = b;
      rr_n         = rr;
      src_n        = src;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      tx_done_tick = 1'b0;
      case (state)
         IDLE:
            // reset outranks any pending request in the same cycle
            if (~reset & (req0 | req1)) begin
               gnt0    = req0 & (~req1 | ~rr);
               gnt1    = ~gnt0;
               b_n     = gnt0 ? din0 : din1;
               src_n   = gnt1;
               rr_n    = gnt0;
               s_n     = '0;
               state_n = START;
            end
         START:
            if (s_tick) begin
               if (s == SW'(15)) begin
                  s_n     = '0;
                  n_n     = '0;
                  state_n = DATA;
               end else
                  s_n = s + SW'(1);
            end
         DATA:
            if (s_tick) begin
               if (s == SW'(15)) begin
                  s_n = '0;
                  b_n = b >> 1;
                  if (n == NW'(DBIT - 1))
                     state_n = STOP;
                  else
                     n_n = n + NW'(1);
               end else
                  s_n = s + SW'(1);
            end
         default:
            if (s_tick) begin
               if (s == SW'(SB_TICK - 1)) begin
                  tx_done_tick = ~reset;
                  state_n      = IDLE;
               end else
                  s_n = s + SW'(1);
            end
      endcase
      tx_n = (state == START) ? 1'b0 : (state == DATA) ? b[0] : 1'b1;
   end
   assign tx_busy = (state != IDLE);
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  one-clk enable pulse at 16x the baud rate, from baud_rate_generator.
REQ-006 req0  input  1  requester 0 has a byte pending; level, held until gnt0.
REQ-007 din0  input  DBIT  requester 0 data; stable while req0 is high.
REQ-008 req1  input  1  requester 1 has a byte pending; level, held until gnt1.
REQ-009 din1  input  DBIT  requester 1 data; stable while req1 is high.
REQ-010 gnt0  output  1  one-clk pulse: din0 accepted.
REQ-011 gnt1  output  1  one-clk pulse: din1 accepted.
REQ-012 src  output  1  index of the requester whose frame is in progress; holds its value after the frame ends.
REQ-013 tx  output  1  serial line; idle high.
REQ-014 tx_busy  output  1  high in every state except IDLE.
REQ-015 tx_done_tick  output  1  one-clk pulse at the end of the stop bit.

Function
REQ-016 FSM states: IDLE, START, DATA, STOP; tick counter s (4 bits, and wide enough to hold SB_TICK-1); bit counter n (wide enough to hold DBIT-1); shift register b (DBIT bits); round-robin pointer rr (1 bit).
REQ-017 IDLE, with at least one request: grant it and, in that same cycle, latch its din into b, set src, clear s, and move to START.
- Grant rule: a single request is granted.
- Both requesting: grant req0 if rr=0, req1 if rr=1.
REQ-018 gnt0/gnt1 are asserted only in that IDLE cycle; they are mutually exclusive; at most one grant per frame.
REQ-019 After each grant, rr points to the requester that was not granted.
REQ-020 A request that drops before it is granted receives no grant and causes no frame.
REQ-021 START: tx=0.
- On s_tick with s=15: clear s, clear n, move to DATA.
- Any other s_tick: increment s.
REQ-022 DATA: tx=b[0].
- On s_tick with s=15: clear s and shift b right by 1.
- If n=DBIT-1 at that point, move to STOP; otherwise increment n.
- Any other s_tick: increment s.
- Data goes out LSB first.
REQ-023 STOP: tx=1.
- On s_tick with s=SB_TICK-1: assert tx_done_tick for that cycle and move to IDLE.
- Any other s_tick: increment s.
REQ-024 Cycles without s_tick leave s, n, b and the state unchanged.
REQ-025 tx is registered; it takes the new state's value one clk after the transition.
REQ-026 Back-to-back frames: a request pending during tx_done_tick is granted in the following IDLE cycle. This gives exactly one idle clk between frames.
REQ-027 Frame length is (1+DBIT)*16 + SB_TICK s_ticks: 160 for the defaults.
REQ-028 Requests arriving during START, DATA or STOP are not granted until IDLE; the frame in flight is never altered.
REQ-029 s_tick coinciding with a grant cycle is ignored; START counting begins at the next s_tick.

Reset
REQ-030 While reset is high at a clk edge, the next state is:
- state=IDLE, s=0, n=0, b=0, rr=0, src=0
- tx=1
- gnt0=gnt1=0, tx_busy=0, tx_done_tick=0
REQ-031 Reset mid-frame aborts the frame: tx returns high one clk later and there is no tx_done_tick. A request still held after reset is re-granted as a new frame.
REQ-032 Reset takes priority over every request and s_tick in the same cycle.

Verification
REQ-033 Single frame: reset, then req0=1 with din0=8'hA5, s_tick every 4 clk.
- gnt0 pulses once.
- tx shows 0 for 16 ticks, then bits 1,0,1,0,0,1,0,1, then 1 for 16 ticks.
- tx_done_tick fires after 160 ticks.
REQ-034 Contention: req0 and req1 both high from reset, din0=8'h11, din1=8'h22, both held after their grants.
- Grant order: gnt0, gnt1, gnt0, gnt1, ...
- src alternates 0,1,0,1.
- Exactly one idle clk between frames.
REQ-035 Single requester: req1 only, held for 3 frames -> three consecutive gnt1, rr ends at 0, src stays 1.
REQ-036 Withdrawn request: req1 pulses for 2 clk while a req0 frame is in STOP -> no gnt1 and no second frame.
REQ-037 Mid-frame reset: reset asserted for 1 clk during DATA bit 3 -> tx=1 next clk, tx_busy=0, no tx_done_tick; the held req0 is re-granted 1 clk after reset deasserts.
REQ-038 SB_TICK=32: one frame spans 176 s_ticks, and the stop bit holds tx=1 for 32 ticks.
